// File: rtl/adc128s_model.sv
// adc128s_model: behavioural SPI model of an ADC128S-style converter.
// SS_n/SCLK are resynchronised into the clk domain. Each 16-bit frame
// returns the conversion addressed by the previous completed frame.
// Optional build macro: ADC_UNMAPPED_ID_EN. When it is defined, unmapped
// channels return 12'hE00 | channel. When it is not defined, they return 0.
module adc128s_model (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt
);

  logic        ss_ff1, ss_sync, ss_prev;
  logic        sclk_ff1, sclk_sync, sclk_prev;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [15:0] tx, rx;
  logic [4:0]  bit_cnt;
  logic [2:0]  channel;
  logic [11:0] result;
  logic [2:0]  ch_sel;
  logic [11:0] conv;

  // Two-flop synchronisers plus a previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_ff1    <= 1'b1;
      ss_sync   <= 1'b1;
      ss_prev   <= 1'b1;
      sclk_ff1  <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      ss_ff1    <= SS_n;
      ss_sync   <= ss_ff1;
      ss_prev   <= ss_sync;
      sclk_ff1  <= SCLK;
      sclk_sync <= sclk_ff1;
      sclk_prev <= sclk_sync;
    end
  end

  // Edge strobes derived from the synchronised values
  always_comb begin
    ss_fall   = ~ss_sync & ss_prev;
    ss_rise   = ss_sync & ~ss_prev;
    sclk_rise = sclk_sync & ~sclk_prev;
    sclk_fall = ~sclk_sync & sclk_prev;
  end

  // Channel decode of the command just received
  always_comb begin
    ch_sel = rx[13:11];
    case (ch_sel)
      3'd0:    conv = lft_ld;
      3'd4:    conv = rght_ld;
      3'd5:    conv = batt;
`ifdef ADC_UNMAPPED_ID_EN
      default: conv = {9'b111000000, ch_sel};
`else
      default: conv = '0;
`endif
    endcase
  end

  // Frame shifter: load on select, sample on SCLK rise, shift out on SCLK fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
    end else if (ss_fall) begin
      tx      <= {4'h0, result};
      bit_cnt <= '0;
    end else if (!ss_sync) begin
      if (sclk_rise) begin
        rx <= {rx[14:0], MOSI};
        if (bit_cnt != 5'd16)
          bit_cnt <= bit_cnt + 5'd1;
      end
      if (sclk_fall)
        tx <= {tx[14:0], 1'b0};
    end
  end

  // Capture the addressed conversion only at the end of a complete frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      channel <= '0;
      result  <= '0;
    end else if (ss_rise && (bit_cnt == 5'd16)) begin
      channel <= ch_sel;
      result  <= conv;
    end
  end

  // MISO is gated by the raw select so it idles low between frames
  always_comb begin
    MISO = ~SS_n & tx[15];
  end

endmodule

// File: tb/tb_adc128s_model.sv
// Scoreboard bench for adc128s_model: the driver queues expected words,
// and the monitor compares each received frame as it is presented.
module tb_adc128s_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [11:0] lft_ld = 12'h500;
  logic [11:0] rght_ld = 12'h250;
  logic [11:0] batt = 12'h810;

`ifdef ADC_UNMAPPED_ID_EN
  localparam logic [15:0] UNMAP3 = 16'h0E03;
`else
  localparam logic [15:0] UNMAP3 = 16'h0000;
`endif

  always #5 clk = ~clk;

  adc128s_model dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .lft_ld  (lft_ld),
    .rght_ld (rght_ld),
    .batt    (batt)
  );

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [15:0] obs_word = '0;
  logic        obs_valid = 1'b0;
  logic [15:0] exp_word;
  string       exp_name;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input string nm, input logic [15:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic present(input logic [15:0] w);
    @(posedge clk);
    obs_word  = w;
    obs_valid = 1'b1;
    @(posedge clk);
    obs_valid = 1'b0;
  endtask

  task automatic sclk_bit(input logic b, output logic m);
    MOSI = b;
    wait_clk(8);
    m = MISO;
    SCLK = 1'b1;
    wait_clk(8);
    SCLK = 1'b0;
  endtask

  task automatic frame(input string nm, input logic [15:0] cmd,
                       input int unsigned nbits, input logic chk,
                       input logic [15:0] e);
    logic [15:0] rd;
    logic [15:0] ext;
    logic        m;
    rd  = '0;
    ext = '0;
    if (chk) begin
      expect_word(nm, e);
      if (nbits > 16) expect_word({nm, "_tail"}, 16'h0000);
    end
    wait_clk(1);
    SS_n = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) begin
      sclk_bit((i < 16) ? cmd[15-i] : 1'b0, m);
      if (i < 16) rd = {rd[14:0], m};
      else        ext = {ext[14:0], m};
    end
    wait_clk(8);
    SS_n = 1'b1;
    wait_clk(8);
    if (chk) begin
      present(rd);
      if (nbits > 16) present(ext);
    end
  endtask

  // Monitor: pop and compare whenever a received word is presented
  always @(negedge clk) begin
    if (obs_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got=%h required=none", obs_word);
      end else begin
        exp_word = exp_q.pop_front();
        exp_name = name_q.pop_front();
        if (obs_word !== exp_word) begin
          n_fail++;
          $display("FAIL %s got=%h required=%h", exp_name, obs_word, exp_word);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic m;
    wait_clk(3);
    expect_word("rst_miso", 16'h0000);
    present({15'b0, MISO});
    rst_n = 1'b1;
    wait_clk(4);

    frame("first_after_rst", 16'h0000, 16, 1'b1, 16'h0000);
    frame("ch0_lft",         16'h2000, 16, 1'b1, 16'h0500);
    frame("ch4_rght",        16'h2800, 16, 1'b1, 16'h0250);
    frame("ch5_batt",        16'h0000, 16, 1'b1, 16'h0810);
    batt = 12'h755;
    frame("pre_hold",        16'h2800, 16, 1'b1, 16'h0500);
    batt = 12'h700;
    frame("batt_held",       16'h0000, 16, 1'b1, 16'h0755);
    frame("abort",           16'h2000, 8,  1'b0, 16'h0000);
    frame("after_abort",     16'h0000, 16, 1'b1, 16'h0500);

    // SCLK activity with select high must not disturb the next frame
    for (int i = 0; i < 4; i++) begin
      wait_clk(8);
      SCLK = 1'b1;
      MOSI = 1'b1;
      wait_clk(8);
      SCLK = 1'b0;
    end
    MOSI = 1'b0;

    frame("idle_sclk",       16'h1800, 16, 1'b1, 16'h0500);
    frame("ch3_unmapped",    16'h0000, 16, 1'b1, UNMAP3);
    lft_ld = 12'h3A5;
    frame("overlong",        16'h0000, 18, 1'b1, 16'h0500);
    frame("after_overlong",  16'h2000, 16, 1'b1, 16'h03A5);

    // Reset in the middle of a frame
    wait_clk(1);
    SS_n = 1'b0;
    for (int i = 0; i < 6; i++) sclk_bit(1'b1, m);
    rst_n = 1'b0;
    wait_clk(3);
    expect_word("rst_mid_miso", 16'h0000);
    present({15'b0, MISO});
    SS_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);

    frame("mid_rst_first",   16'h0000, 16, 1'b1, 16'h0000);
    frame("mid_rst_second",  16'h0000, 16, 1'b1, 16'h03A5);

    wait_clk(4);
    if (exp_q.size() != 0) begin
      n_cmp  += exp_q.size();
      n_fail += exp_q.size();
      $display("FAIL missing_outputs got=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
